fight_match_controller: RTL and testbench
=========================================

# fight_match_controller

Match sequencer for the two-player fighting datapath. Sits between the raw player controls and the left/right player modules. Divides the clock into action ticks and gates each player's one-hot command onto the players for exactly one cycle per tick. Holds the players in reset between rounds, runs the round timer, detects KO and timeout, and keeps the match score up to a match winner.

## Interface
- TICK_DIV, 8: clock cycles per action tick; legal range is 4 or more.
- ROUND_TICKS, 60: action ticks per round, 1–255.
- COUNTDOWN_TICKS, 3: ticks of player reset before each round's FIGHT state.
- ROUND_END_TICKS, 2: ticks of result display after a round ends.
- WINS_TO_MATCH, 2: rounds needed to win the match, 1–3.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; begins a match from IDLE or MATCH_OVER
- left_raw, right_raw  in  6 each  player command: MOVE_RIGHT/MOVE_LEFT/WAIT/JUMP/KICK/PUNCH one-hot, 0 = none
- left_health, right_health  in  3 each  registered health outputs of the player modules
- left_cmd, right_cmd  out  6 each  gated commands to the player modules; 0 except on the issue cycle
- player_rst_n  out  1  active-low reset to both player modules
- state  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_OVER=4
- round_timer  out  8  action ticks remaining in the round
- round_result  out  2  0 none, 1 left won, 2 right won, 3 draw
- left_score, right_score  out  2 each  rounds won
- match_winner  out  2  same encoding as round_result; valid in MATCH_OVER

## Operation
- Tick divider: counts 0..TICK_DIV-1 in every state except IDLE. `tick` is the cycle where the count equals TICK_DIV-1.
- Command validation: a raw value that is not one-hot and not zero is treated as 0.
- IDLE: player_rst_n=0. When start=1, clear both scores, clear the divider, and go to COUNTDOWN.
- COUNTDOWN: player_rst_n=0; round_timer loads ROUND_TICKS; round_result=0. After COUNTDOWN_TICKS ticks, go to FIGHT.
- FIGHT: player_rst_n=1.
  - On each tick with round_timer>0: drive the captured commands on left_cmd/right_cmd for that one cycle, then decrement round_timer.
  - On the tick where round_timer==0: issue no command. This is the timeout decision.
- KO test, evaluated every FIGHT cycle: health==0 or health≥6. Values 6 and 7 are the underflow wrap of a 3-bit health.
- Round end, in priority order:
  - Both players KO → draw.
  - One player KO → the other player wins.
  - Timeout → higher health wins; equal health → draw.
- On round end, latch round_result, increment the winner's score (a draw scores nothing), and go to ROUND_END.
- ROUND_END: commands are 0 and player_rst_n=1, so health stays visible. After ROUND_END_TICKS ticks:
  - If either score equals WINS_TO_MATCH, go to MATCH_OVER and set match_winner.
  - Otherwise go to COUNTDOWN.
- MATCH_OVER: hold scores and match_winner. When start=1, behave as IDLE with start=1.
- rst (any state, including mid-tick): state=IDLE; divider, scores, round_timer, round_result and match_winner=0; cmds=0; player_rst_n=0.

## Timing
- A command issued at tick cycle T is applied by the player at edge T+1. The player's health output reflects it at T+2. The KO test therefore sees the effect by T+2, and TICK_DIV≥4 guarantees it is seen before the next issue.
- State transitions take effect on the edge after the deciding cycle. round_result and the score increment update on that same edge.
- COUNTDOWN→FIGHT happens on a tick edge. The first command issue is TICK_DIV cycles later.
- round_timer is 8-bit and saturates at 0; it never wraps.
- Scores are 2-bit and never exceed WINS_TO_MATCH.

## Configuration
- INPUT_HOLD_EN defined: each player has a capture register. It records the last valid nonzero command seen during the tick window and clears after issue. A press between ticks is therefore not lost.
- INPUT_HOLD_EN undefined: the command is the validated raw input sampled combinationally on the tick cycle only. No capture registers are built.

## Structure
- Shared package, `fight_pkg`:
  - Command one-hot constants (MOVE_RIGHT 100000 … PUNCH 000001).
  - State encoding enum.
  - Result encoding (NONE/LEFT/RIGHT/DRAW).
  - KO threshold constant 6.
- Sub-module `fight_tick_div`: the parameterised divider with clear input and tick output.
- FSM, timer, capture and scoring live in the top-level module.

## Test plan
- Reset mid-FIGHT (round_timer=40) → next cycle: state=0, scores 0, cmds 0, player_rst_n=0.
- start, with TICK_DIV=4, COUNTDOWN_TICKS=3, and right_raw=PUNCH held → right_cmd=000001 for exactly one cycle every 4 cycles, starting 4 cycles after FIGHT entry.
- left_health goes 1→7 (underflow) during FIGHT → round_result=2, right_score=1, state=ROUND_END.
- Both healths drop to 0 in the same cycle → round_result=3, scores unchanged.
- ROUND_TICKS=5 with left_health=3, right_health=2 at timeout → 5 issues, then round_result=1 on the 6th tick.
- Left wins two rounds (WINS_TO_MATCH=2) → MATCH_OVER, match_winner=1. start=1 → scores clear, state=COUNTDOWN.
- INPUT_HOLD_EN defined, right_raw=KICK pulsed for 1 cycle mid-window → right_cmd=KICK at the next tick. The same stimulus without the macro → no issue.
- right_raw=000011 (invalid) → right_cmd stays 0.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared definitions for the fight match controller: command one-hots, FSM
// state and round-result encodings, KO threshold and validation helpers.
package fight_pkg;

  localparam logic [5:0] CMD_MOVE_RIGHT = 6'b100000;
  localparam logic [5:0] CMD_MOVE_LEFT  = 6'b010000;
  localparam logic [5:0] CMD_WAIT       = 6'b001000;
  localparam logic [5:0] CMD_JUMP       = 6'b000100;
  localparam logic [5:0] CMD_KICK       = 6'b000010;
  localparam logic [5:0] CMD_PUNCH      = 6'b000001;
  localparam logic [5:0] CMD_NONE       = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_MATCH_OVER = 3'd4
  } fight_state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_LEFT  = 2'd1,
    RES_RIGHT = 2'd2,
    RES_DRAW  = 2'd3
  } fight_result_e;

  // Health 6 and 7 are the wrap of a 3-bit health going below zero.
  localparam logic [2:0] KO_THRESHOLD = 3'd6;

  function automatic logic [5:0] valid_cmd(input logic [5:0] raw);
    return $onehot(raw) ? raw : CMD_NONE;
  endfunction

  function automatic logic is_ko(input logic [2:0] health);
    return (health == 3'd0) || (health >= KO_THRESHOLD);
  endfunction

endpackage

// File: rtl/fight_tick_div.sv
// Action-tick divider: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module fight_tick_div #(
  parameter int TICK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  import fight_pkg::*;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo counter, restarted by reset, clear or disable.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/fight_match_controller.sv
// Match sequencer: ticks, command gating, round timer, KO/timeout and scoring.
// Optional INPUT_HOLD_EN builds per-player capture registers for presses between ticks.
module fight_match_controller #(
  parameter int TICK_DIV        = 8,
  parameter int ROUND_TICKS     = 60,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_END_TICKS = 2,
  parameter int WINS_TO_MATCH   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] left_raw,
  input  logic [5:0] right_raw,
  input  logic [2:0] left_health,
  input  logic [2:0] right_health,
  output logic [5:0] left_cmd,
  output logic [5:0] right_cmd,
  output logic       player_rst_n,
  output logic [2:0] state,
  output logic [7:0] round_timer,
  output logic [1:0] round_result,
  output logic [1:0] left_score,
  output logic [1:0] right_score,
  output logic [1:0] match_winner
);
  import fight_pkg::*;

  localparam logic [7:0] TIMER_LOAD = 8'(ROUND_TICKS);
  localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_TICKS - 1);
  localparam logic [7:0] RE_LAST    = 8'(ROUND_END_TICKS - 1);
  localparam logic [1:0] WIN_SCORE  = 2'(WINS_TO_MATCH);

  fight_state_e  state_r;
  fight_result_e result_r, winner_r, end_res_s;
  logic [7:0]    timer_r, phase_r;
  logic [1:0]    left_score_r, right_score_r;
  logic          prn_r, tick_s, div_clr_s, div_en_s, issue_s, end_s;
  logic [5:0]    left_valid_s, right_valid_s, left_sel_s, right_sel_s;

  assign div_clr_s = start && ((state_r == ST_IDLE) || (state_r == ST_MATCH_OVER));
  assign div_en_s  = (state_r != ST_IDLE);

  fight_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr_s),
    .en   (div_en_s),
    .tick (tick_s)
  );

  assign left_valid_s  = valid_cmd(left_raw);
  assign right_valid_s = valid_cmd(right_raw);
  assign issue_s = !rst && (state_r == ST_FIGHT) && tick_s && (timer_r != 8'd0);

`ifdef INPUT_HOLD_EN
  logic [5:0] left_cap_r, right_cap_r;

  // Remember the latest valid press of the tick window; cleared on every tick.
  always_ff @(posedge clk) begin
    if (rst || (state_r != ST_FIGHT) || tick_s) begin
      left_cap_r  <= CMD_NONE;
      right_cap_r <= CMD_NONE;
    end else begin
      if (left_valid_s != CMD_NONE) left_cap_r <= left_valid_s;
      if (right_valid_s != CMD_NONE) right_cap_r <= right_valid_s;
    end
  end

  assign left_sel_s  = (left_valid_s != CMD_NONE) ? left_valid_s : left_cap_r;
  assign right_sel_s = (right_valid_s != CMD_NONE) ? right_valid_s : right_cap_r;
`else
  assign left_sel_s  = left_valid_s;
  assign right_sel_s = right_valid_s;
`endif

  // Players sample the command on the edge after the tick, so it is driven in the tick cycle.
  assign left_cmd  = issue_s ? left_sel_s : CMD_NONE;
  assign right_cmd = issue_s ? right_sel_s : CMD_NONE;

  // Round-end decision: KO outranks timeout, double KO is a draw.
  always_comb begin
    end_s     = 1'b0;
    end_res_s = RES_NONE;
    if (is_ko(left_health) && is_ko(right_health)) begin
      end_s     = 1'b1;
      end_res_s = RES_DRAW;
    end else if (is_ko(left_health)) begin
      end_s     = 1'b1;
      end_res_s = RES_RIGHT;
    end else if (is_ko(right_health)) begin
      end_s     = 1'b1;
      end_res_s = RES_LEFT;
    end else if (tick_s && (timer_r == 8'd0)) begin
      end_s = 1'b1;
      if (left_health > right_health) begin
        end_res_s = RES_LEFT;
      end else if (right_health > left_health) begin
        end_res_s = RES_RIGHT;
      end else begin
        end_res_s = RES_DRAW;
      end
    end else begin
      end_s     = 1'b0;
      end_res_s = RES_NONE;
    end
  end

  // Match FSM with timer, phase tick counter, scoring and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      timer_r       <= 8'd0;
      phase_r       <= 8'd0;
      result_r      <= RES_NONE;
      winner_r      <= RES_NONE;
      left_score_r  <= 2'd0;
      right_score_r <= 2'd0;
      prn_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_MATCH_OVER: begin
          if (start) begin
            state_r       <= ST_COUNTDOWN;
            left_score_r  <= 2'd0;
            right_score_r <= 2'd0;
            winner_r      <= RES_NONE;
            result_r      <= RES_NONE;
            phase_r       <= 8'd0;
            prn_r         <= 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          timer_r  <= TIMER_LOAD;
          result_r <= RES_NONE;
          prn_r    <= 1'b0;
          if (tick_s) begin
            if (phase_r == CD_LAST) begin
              phase_r <= 8'd0;
              state_r <= ST_FIGHT;
              prn_r   <= 1'b1;
            end else begin
              phase_r <= phase_r + 8'd1;
            end
          end
        end
        ST_FIGHT: begin
          if (issue_s) timer_r <= timer_r - 8'd1;
          if (end_s) begin
            result_r <= end_res_s;
            if (end_res_s == RES_LEFT) left_score_r <= left_score_r + 2'd1;
            if (end_res_s == RES_RIGHT) right_score_r <= right_score_r + 2'd1;
            state_r <= ST_ROUND_END;
            phase_r <= 8'd0;
          end
        end
        ST_ROUND_END: begin
          if (tick_s) begin
            if (phase_r == RE_LAST) begin
              phase_r <= 8'd0;
              prn_r   <= 1'b0;
              if ((left_score_r == WIN_SCORE) || (right_score_r == WIN_SCORE)) begin
                state_r  <= ST_MATCH_OVER;
                winner_r <= (left_score_r == WIN_SCORE) ? RES_LEFT : RES_RIGHT;
              end else begin
                state_r <= ST_COUNTDOWN;
              end
            end else begin
              phase_r <= phase_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          prn_r   <= 1'b0;
        end
      endcase
    end
  end

  assign player_rst_n = prn_r;
  assign state        = state_r;
  assign round_timer  = timer_r;
  assign round_result = result_r;
  assign left_score   = left_score_r;
  assign right_score  = right_score_r;
  assign match_winner = winner_r;

endmodule

// File: tb/tb_fight_match_controller.sv
// Randomized + directed bench for fight_match_controller against a behavioural match model.
module tb_fight_match_controller;

  localparam int TD = 4, RT = 5, CDT = 3, RET = 2, WTM = 2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [5:0] left_raw, right_raw, left_cmd, right_cmd;
  logic [2:0] left_health, right_health, state;
  logic       player_rst_n;
  logic [7:0] round_timer;
  logic [1:0] round_result, left_score, right_score, match_winner;

  always #5 clk = ~clk;

  fight_match_controller #(
    .TICK_DIV(TD), .ROUND_TICKS(RT), .COUNTDOWN_TICKS(CDT),
    .ROUND_END_TICKS(RET), .WINS_TO_MATCH(WTM)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .left_raw(left_raw), .right_raw(right_raw),
    .left_health(left_health), .right_health(right_health),
    .left_cmd(left_cmd), .right_cmd(right_cmd),
    .player_rst_n(player_rst_n), .state(state), .round_timer(round_timer),
    .round_result(round_result), .left_score(left_score),
    .right_score(right_score), .match_winner(match_winner)
  );

  int n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase names 0 idle,1 countdown,2 fight,3 round end,4 match over.
  int m_state, m_div, m_ticks, m_timer, m_res, m_ls, m_rs, m_win, m_prn;
  logic [5:0] m_lcap, m_rcap;

  function automatic logic [5:0] legal(input logic [5:0] x);
    return (x != 6'd0 && (x & (x - 6'd1)) == 6'd0) ? x : 6'd0;
  endfunction

  function automatic bit knocked(input logic [2:0] h);
    return (h == 3'd0) || (h > 3'd5);
  endfunction

  function automatic logic [5:0] rand_cmd();
    int k;
    logic [5:0] one;
    k = $urandom_range(0, 9);
    one = 6'd1;
    if (k == 0) return 6'd0;
    if (k <= 6) return one << (k - 1);
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic model_reset();
    m_state = 0; m_div = 0; m_ticks = 0; m_timer = 0; m_res = 0;
    m_ls = 0; m_rs = 0; m_win = 0; m_prn = 0; m_lcap = 6'd0; m_rcap = 6'd0;
  endtask

  // One clock: drive at negedge, check, then advance the model to the next edge.
  task automatic cycle(input logic r, input logic s, input logic [5:0] lr, input logic [5:0] rr,
                       input logic [2:0] lh, input logic [2:0] rh);
    bit tick, issue, timeout;
    logic [5:0] lv, rv, el, er;
    int nstate, w;
    @(negedge clk);
    rst = r; start = s; left_raw = lr; right_raw = rr; left_health = lh; right_health = rh;
    #1;
    check_eq("state", int'(state), m_state);
    check_eq("round_timer", int'(round_timer), m_timer);
    check_eq("round_result", int'(round_result), m_res);
    check_eq("left_score", int'(left_score), m_ls);
    check_eq("right_score", int'(right_score), m_rs);
    check_eq("match_winner", int'(match_winner), m_win);
    check_eq("player_rst_n", int'(player_rst_n), m_prn);
    tick = (m_state != 0) && (m_div == TD - 1);
    lv = legal(lr);
    rv = legal(rr);
    issue = !r && (m_state == 2) && tick && (m_timer > 0);
    timeout = (m_state == 2) && tick && (m_timer == 0);
`ifdef INPUT_HOLD_EN
    el = issue ? ((lv != 6'd0) ? lv : m_lcap) : 6'd0;
    er = issue ? ((rv != 6'd0) ? rv : m_rcap) : 6'd0;
`else
    el = issue ? lv : 6'd0;
    er = issue ? rv : 6'd0;
`endif
    check_eq("left_cmd", int'(left_cmd), int'(el));
    check_eq("right_cmd", int'(right_cmd), int'(er));
    if (r) begin
      model_reset();
    end else begin
      nstate = m_state;
      if (m_state == 2 && !tick) begin
        if (lv != 6'd0) m_lcap = lv;
        if (rv != 6'd0) m_rcap = rv;
      end else begin
        m_lcap = 6'd0; m_rcap = 6'd0;
      end
      if (m_state == 0 || ((m_state == 4) && s)) m_div = 0;
      else m_div = (m_div + 1) % TD;
      case (m_state)
        0, 4: if (s) begin
          nstate = 1; m_ls = 0; m_rs = 0; m_win = 0; m_res = 0; m_ticks = 0; m_prn = 0;
        end
        1: begin
          m_timer = RT; m_res = 0;
          if (tick) begin
            m_ticks++;
            if (m_ticks == CDT) begin m_ticks = 0; nstate = 2; m_prn = 1; end
          end
        end
        2: begin
          if (issue) m_timer--;
          w = 0;
          if (knocked(lh) && knocked(rh)) w = 3;
          else if (knocked(lh)) w = 2;
          else if (knocked(rh)) w = 1;
          else if (timeout) w = (lh > rh) ? 1 : ((rh > lh) ? 2 : 3);
          if (w != 0) begin
            m_res = w;
            if (w == 1) m_ls++;
            if (w == 2) m_rs++;
            nstate = 3; m_ticks = 0;
          end
        end
        3: if (tick) begin
          m_ticks++;
          if (m_ticks == RET) begin
            m_ticks = 0; m_prn = 0;
            if (m_ls == WTM || m_rs == WTM) begin
              nstate = 4; m_win = (m_ls == WTM) ? 1 : 2;
            end else begin
              nstate = 1;
            end
          end
        end
        default: nstate = 0;
      endcase
      m_state = nstate;
    end
  endtask

  // Bounded wait until the model reaches a phase, keeping the inputs held.
  task automatic run_to(input int target, input logic [5:0] lr, input logic [5:0] rr,
                        input logic [2:0] lh, input logic [2:0] rh);
    int n;
    n = 0;
    while (m_state != target && n < 400) begin
      cycle(1'b0, 1'b0, lr, rr, lh, rh);
      n++;
    end
    if (m_state != target) begin
      n_total++; n_bad++;
      $display("FAIL wait_state got=%0d exp=%0d", m_state, target);
    end
  endtask

  task automatic new_match();
    cycle(1'b1, 1'b0, 6'd0, 6'd0, 3'd5, 3'd5);
    cycle(1'b0, 1'b1, 6'd0, 6'd0, 3'd5, 3'd5);
  endtask

  logic [2:0] lh, rh;

  initial begin
    rst = 1'b1; start = 1'b0; left_raw = 6'd0; right_raw = 6'd0;
    left_health = 3'd5; right_health = 3'd5;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(1'b1, 1'b0, 6'd0, 6'd0, 3'd5, 3'd5);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd5, 3'd5);

    // Held PUNCH through a whole round, equal health -> timeout draw.
    new_match();
    repeat (70) cycle(1'b0, 1'b0, 6'd0, 6'b000001, 3'd4, 3'd4);

    // Reset mid-fight.
    new_match();
    run_to(2, 6'b010000, 6'd0, 3'd4, 3'd4);
    repeat (6) cycle(1'b0, 1'b0, 6'b010000, 6'd0, 3'd4, 3'd4);
    cycle(1'b1, 1'b0, 6'b010000, 6'd0, 3'd4, 3'd4);
    repeat (3) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd4, 3'd4);

    // Left health underflows 1 -> 7: right wins.
    new_match();
    run_to(2, 6'd0, 6'd0, 3'd1, 3'd4);
    repeat (3) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd1, 3'd4);
    repeat (6) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd7, 3'd4);

    // Double KO in the same cycle: draw, scores unchanged.
    run_to(2, 6'd0, 6'd0, 3'd3, 3'd3);
    repeat (2) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd3, 3'd3);
    repeat (4) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd0, 3'd0);

    // One-cycle KICK between ticks, then invalid 000011 held.
    run_to(2, 6'd0, 6'd0, 3'd4, 3'd4);
    begin
      int n;
      n = 0;
      while (!(m_div == 1 && m_timer > 0) && n < 20) begin
        cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd4, 3'd4);
        n++;
      end
    end
    cycle(1'b0, 1'b0, 6'd0, 6'b000010, 3'd4, 3'd4);
    repeat (4) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd4, 3'd4);
    repeat (8) cycle(1'b0, 1'b0, 6'd0, 6'b000011, 3'd4, 3'd4);

    // Left 3 vs right 2 at every timeout: left takes the match, then restart.
    new_match();
    run_to(4, 6'b001000, 6'b000100, 3'd3, 3'd2);
    repeat (5) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd3, 3'd2);
    cycle(1'b0, 1'b1, 6'd0, 6'd0, 3'd3, 3'd2);
    repeat (3) cycle(1'b0, 1'b0, 6'd0, 6'd0, 3'd3, 3'd2);

    // Randomized matches with hits, underflows, invalid presses and stray resets.
    lh = 3'd5; rh = 3'd5;
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      r = ($urandom_range(0, 599) == 0);
      s = (m_state == 0 || m_state == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      if (m_prn == 0) begin
        lh = 3'($urandom_range(1, 5));
        rh = 3'($urandom_range(1, 5));
      end else begin
        if ($urandom_range(0, 15) == 0) lh = lh - 3'd1;
        if ($urandom_range(0, 15) == 0) rh = rh - 3'd1;
      end
      cycle(r, s, rand_cmd(), rand_cmd(), lh, rh);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
